// File: rtl/ipsxe_floating_point_apm_a0lo_a1y_arb_v1_0.sv
// Two-channel round-robin front end for one shared a0_lo +/- a1*y APM.
// Requests are issued through a registered stage and tagged so each result returns with its channel.
module ipsxe_floating_point_apm_a0lo_a1y_arb_v1_0 #(
    parameter int MAN_WIDTH          = 52,
    parameter int RNE                = 2,
    parameter int LATENCY_CONFIG     = 1,
    parameter int PIPE_STAGE_NUM_MAX = 1,
    localparam int DW                = MAN_WIDTH + 1 + RNE - 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ch0_valid,
    output logic          o_ch0_ready,
    input  logic [DW-1:0] i_ch0_a0_lo,
    input  logic [DW-1:0] i_ch0_a1_y,
    input  logic          i_ch0_sub,
    input  logic          i_ch1_valid,
    output logic          o_ch1_ready,
    input  logic [DW-1:0] i_ch1_a0_lo,
    input  logic [DW-1:0] i_ch1_a1_y,
    input  logic          i_ch1_sub,
    output logic [DW-1:0] o_apm_a0_lo,
    output logic [DW-1:0] o_apm_a1_y,
    output logic          o_apm_sub,
    input  logic [47:0]   i_apm_p,
    output logic          o_res_valid,
    output logic          o_res_ch,
    output logic [47:0]   o_res,
    output logic          o_busy
);

    // Depth of the APM X/Y/Z input registers; the tag pipeline must match it.
    localparam int APM_LAT = (LATENCY_CONFIG >= PIPE_STAGE_NUM_MAX / 4 - 2) ? 1 : 0;

    logic               last_grant_r;
    logic               grant0_s;
    logic               grant1_s;
    logic [DW-1:0]      apm_a0_lo_r;
    logic [DW-1:0]      apm_a1_y_r;
    logic               apm_sub_r;
    logic [APM_LAT:0]   tag_v_r;
    logic [APM_LAT:0]   tag_ch_r;
    logic               res_valid_r;
    logic               res_ch_r;
    logic [47:0]        res_r;

    // Round-robin grant: on a tie the channel that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!i_rst_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (i_ch0_valid && i_ch1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = i_ch0_valid;
            grant1_s = i_ch1_valid;
        end
    end

    // Issue stage, grant pointer and tag shift register; operands hold between grants.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant_r <= 1'b1;
            apm_a0_lo_r  <= {DW{1'b0}};
            apm_a1_y_r   <= {DW{1'b0}};
            apm_sub_r    <= 1'b0;
            tag_v_r      <= {(APM_LAT + 1){1'b0}};
            tag_ch_r     <= {(APM_LAT + 1){1'b0}};
        end else begin
            if (grant0_s) begin
                last_grant_r <= 1'b0;
                apm_a0_lo_r  <= i_ch0_a0_lo;
                apm_a1_y_r   <= i_ch0_a1_y;
                apm_sub_r    <= i_ch0_sub;
                tag_v_r[0]   <= 1'b1;
                tag_ch_r[0]  <= 1'b0;
            end else if (grant1_s) begin
                last_grant_r <= 1'b1;
                apm_a0_lo_r  <= i_ch1_a0_lo;
                apm_a1_y_r   <= i_ch1_a1_y;
                apm_sub_r    <= i_ch1_sub;
                tag_v_r[0]   <= 1'b1;
                tag_ch_r[0]  <= 1'b1;
            end else begin
                tag_v_r[0]   <= 1'b0;
            end
            for (int i = 1; i <= APM_LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_ch_r[i] <= tag_ch_r[i-1];
            end
        end
    end

    // Output stage: capture the APM product when its tag emerges.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            res_valid_r <= 1'b0;
            res_ch_r    <= 1'b0;
            res_r       <= 48'd0;
        end else begin
            res_valid_r <= tag_v_r[APM_LAT];
            if (tag_v_r[APM_LAT]) begin
                res_ch_r <= tag_ch_r[APM_LAT];
                res_r    <= i_apm_p;
            end else begin
                res_ch_r <= res_ch_r;
                res_r    <= res_r;
            end
        end
    end

    assign o_ch0_ready = grant0_s;
    assign o_ch1_ready = grant1_s;
    assign o_apm_a0_lo = apm_a0_lo_r;
    assign o_apm_a1_y  = apm_a1_y_r;
    assign o_apm_sub   = apm_sub_r;
    assign o_res_valid = res_valid_r;
    assign o_res_ch    = res_ch_r;
    assign o_res       = res_r;
    assign o_busy      = (|tag_v_r) | res_valid_r;

endmodule
